io_access_sequencer: RTL
========================

# io_access_sequencer

Bus-side initiator for the GPIO register block. It accepts single I/O-space operations from the core: IN, OUT, and the read-modify-write bit operations SBI and CBI. Each operation is decoded against the ATmega32A port A/B addresses. The block drives the per-register write enables and shared write data into the GPIO block, and it returns register read data to the core. It sits between the instruction execute stage and the gpio instance, clocked by the same system clock.

## Interface
- No parameters. Address map and opcodes are fixed constants.
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- req  input  1  operation request; sampled only in IDLE.
- op  input  2  operation code: 0 = IN, 1 = OUT, 2 = SBI, 3 = CBI.
- io_addr  input  6  I/O address. Map: PINB=0x16, DDRB=0x17, PORTB=0x18, PINA=0x19, DDRA=0x1A, PORTA=0x1B.
- bit_sel  input  3  bit index used by SBI/CBI.
- wdata  input  8  write data used by OUT.
- pina_in, ddra_in, porta_in, pinb_in, ddrb_in, portb_in  input  8 each  current GPIO register values.
- wr_data  output  8  shared write data to the GPIO block.
- ddra_we, porta_we, ddrb_we, portb_we  output  1 each  single-cycle register write enables.
- rdata  output  8  result of the last IN; holds its value until the next IN completes.
- busy  output  1  an operation is in progress.
- done  output  1  single-cycle completion pulse.
- err  output  1  qualifies done; high when the operation was illegal.

## Operation
- States: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - When req=1, latch op, io_addr, bit_sel and wdata, then go to ACCESS.
  - When req=0, stay in IDLE.
- ACCESS:
  - IN: capture the selected register into rdata, then go to DONE.
  - OUT: assert the selected write enable with wr_data=wdata, then go to DONE.
  - SBI/CBI: capture the selected register into an internal temp, then go to WRITE.
- WRITE: assert the selected write enable.
  - SBI: wr_data = temp | (1<<bit_sel).
  - CBI: wr_data = temp & ~(1<<bit_sel).
  - Then go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Legality:
  - Any read of the six mapped addresses is legal.
  - Writes (OUT/SBI/CBI) are legal only to DDRx and PORTx.
  - Writes to PINx, and any access to an unmapped address, are illegal.
  - Illegal operations assert no write enable; err=1 with done.
  - An illegal IN leaves rdata unchanged.
  - An illegal SBI/CBI skips WRITE: ACCESS goes straight to DONE.
- At most one write enable is high in any cycle. All enables are low outside the write cycle.
- wr_data is 0x00 whenever no write enable is asserted.
- req is ignored while busy, including the DONE cycle. It is not queued.

## Timing
- Request accepted at cycle N (req=1 in IDLE).
- IN/OUT: register access at N+1, done at N+2.
- SBI/CBI: read sampled at N+1, write enable at N+2, done at N+3.
- busy is high from N+1 through the done cycle inclusive. The earliest next acceptance is done+1.
- Read data is sampled at the end of the ACCESS cycle. GPIO register updates take effect on the edge ending the write-enable cycle.
- An SBI/CBI whose temp holds a stale PIN value is not possible, because only DDRx and PORTx are writable.
- Reset values: state IDLE; every output 0, including rdata=0x00; temp cleared.
- Reset asserted mid-operation aborts immediately. No further write enable or done is produced for that operation.
- A write already completed before reset is not undone.
- All outputs are registered.

## Structure
- Shared package (io_defs): address constants, opcode encodings, state encoding.
- One combinational sub-module, io_addr_decode. Inputs: io_addr and a write flag. Outputs: a one-hot register select and a legal bit.
- The top contains the FSM, latches, read mux and bit-modify logic.

## Test plan
- OUT 0xA5 to PORTA (0x1B) -> porta_we high for exactly one cycle at N+1 with wr_data=0xA5; done at N+2; err=0.
- IN from PINA (0x19) with pina_in=0x3C -> rdata=0x3C after N+1; done at N+2; no write enable asserted at any point.
- SBI PORTB (0x18) bit 7 with portb_in=0x01 -> portb_we at N+2 with wr_data=0x81; done at N+3.
- CBI DDRA (0x1A) bit 0 with ddra_in=0xFF -> ddra_we at N+2 with wr_data=0xFE; done at N+3.
- OUT to PINB (0x16) and IN from unmapped 0x00 -> no write enables; done with err=1; rdata keeps its prior value.
- Reset asserted at N+1 of an SBI -> no write enable and no done; all outputs 0; an IN accepted after reset release completes normally.

Source files
------------

// File: rtl/io_defs.sv
// io_defs: shared constants for the I/O access sequencer.
//   - I/O addresses of the port A/B registers (ATmega32A map)
//   - operation codes and FSM state encoding
//   - one-hot register select bit positions
//   - bit_modify helper for the SBI/CBI read-modify-write
package io_defs;

    localparam logic [5:0] AddrPinb  = 6'h16;
    localparam logic [5:0] AddrDdrb  = 6'h17;
    localparam logic [5:0] AddrPortb = 6'h18;
    localparam logic [5:0] AddrPina  = 6'h19;
    localparam logic [5:0] AddrDdra  = 6'h1A;
    localparam logic [5:0] AddrPorta = 6'h1B;

    typedef enum logic [1:0] {
        OpIn  = 2'd0,
        OpOut = 2'd1,
        OpSbi = 2'd2,
        OpCbi = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWrite,
        StDone
    } state_e;

    // Bit positions inside the one-hot register select vector.
    localparam int unsigned NumRegs  = 6;
    localparam int unsigned SelPina  = 0;
    localparam int unsigned SelDdra  = 1;
    localparam int unsigned SelPorta = 2;
    localparam int unsigned SelPinb  = 3;
    localparam int unsigned SelDdrb  = 4;
    localparam int unsigned SelPortb = 5;

    // Set (set=1) or clear (set=0) bit idx of value.
    function automatic logic [7:0] bit_modify(input logic [7:0] value,
                                              input logic [2:0] idx,
                                              input logic       set);
        logic [7:0] mask;
        mask = 8'h01 << idx;
        return set ? (value | mask) : (value & ~mask);
    endfunction

endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: combinational I/O address decoder.
// Ports:
//   addr   in  6  I/O address
//   write  in  1  operation writes the register (OUT/SBI/CBI)
//   sel    out 6  one-hot register select (bit positions from io_defs)
//   legal  out 1  address is mapped and, for writes, is a DDRx/PORTx register
module io_addr_decode
    import io_defs::*;
(
    input  logic [5:0]         addr,
    input  logic               write,
    output logic [NumRegs-1:0] sel,
    output logic               legal
);

    always_comb begin
        sel = '0;
        case (addr)
            AddrPina:  sel[SelPina]  = 1'b1;
            AddrDdra:  sel[SelDdra]  = 1'b1;
            AddrPorta: sel[SelPorta] = 1'b1;
            AddrPinb:  sel[SelPinb]  = 1'b1;
            AddrDdrb:  sel[SelDdrb]  = 1'b1;
            AddrPortb: sel[SelPortb] = 1'b1;
            default:   sel = '0;
        endcase
    end

    // PIN registers are read-only.
    assign legal = (|sel) & ~(write & (sel[SelPina] | sel[SelPinb]));

endmodule

// File: rtl/io_access_sequencer.sv
// io_access_sequencer: executes single IN/OUT/SBI/CBI operations against
// the GPIO port A/B registers.
// Ports:
//   clk, clr                 clock, asynchronous active-high reset
//   req, op, io_addr,        operation request and its operands
//   bit_sel, wdata
//   pina_in .. portb_in      current GPIO register values
//   wr_data                  shared write data (0x00 when no enable is high)
//   ddra_we .. portb_we      single-cycle register write enables
//   rdata                    result of the last legal IN
//   busy, done, err          status; err qualifies done
// Every output comes straight from a flop: the next-cycle values are
// computed one state ahead in the next-state logic.
module io_access_sequencer
    import io_defs::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [5:0] io_addr,
    input  logic [2:0] bit_sel,
    input  logic [7:0] wdata,
    input  logic [7:0] pina_in,
    input  logic [7:0] ddra_in,
    input  logic [7:0] porta_in,
    input  logic [7:0] pinb_in,
    input  logic [7:0] ddrb_in,
    input  logic [7:0] portb_in,
    output logic [7:0] wr_data,
    output logic       ddra_we,
    output logic       porta_we,
    output logic       ddrb_we,
    output logic       portb_we,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [2:0]         bit_q, bit_d;
    logic [NumRegs-1:0] sel_q, sel_d;
    logic               legal_q, legal_d;
    // wr_data_q doubles as the latched OUT data and as the SBI/CBI temp:
    // it is loaded with the modified read value at the end of ACCESS.
    logic [7:0]         wr_data_q, wr_data_d;
    logic [3:0]         we_q, we_d;     // {ddra, porta, ddrb, portb}
    logic [7:0]         rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [NumRegs-1:0] dec_sel;
    logic               dec_legal;
    logic [7:0]         read_val;

    // Decode is done once at acceptance; the select and legality are latched.
    io_addr_decode u_decode (
        .addr  (io_addr),
        .write (op != OpIn),
        .sel   (dec_sel),
        .legal (dec_legal)
    );

    always_comb begin
        read_val = 8'h00;
        if (sel_q[SelPina])  read_val = read_val | pina_in;
        if (sel_q[SelDdra])  read_val = read_val | ddra_in;
        if (sel_q[SelPorta]) read_val = read_val | porta_in;
        if (sel_q[SelPinb])  read_val = read_val | pinb_in;
        if (sel_q[SelDdrb])  read_val = read_val | ddrb_in;
        if (sel_q[SelPortb]) read_val = read_val | portb_in;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        bit_d     = bit_q;
        sel_d     = sel_q;
        legal_d   = legal_q;
        wr_data_d = 8'h00;
        we_d      = 4'b0000;
        rdata_d   = rdata_q;

        case (state_q)
            StIdle: begin
                if (req) begin
                    op_d    = op_e'(op);
                    bit_d   = bit_sel;
                    sel_d   = dec_sel;
                    legal_d = dec_legal;
                    state_d = StAccess;
                    // OUT writes during ACCESS, so its enable is loaded now.
                    if ((op == OpOut) && dec_legal) begin
                        we_d      = {dec_sel[SelDdra], dec_sel[SelPorta],
                                     dec_sel[SelDdrb], dec_sel[SelPortb]};
                        wr_data_d = wdata;
                    end
                end
            end
            StAccess: begin
                state_d = StDone;
                unique case (op_q)
                    OpIn: begin
                        if (legal_q) rdata_d = read_val;
                    end
                    OpOut: begin
                    end
                    OpSbi, OpCbi: begin
                        if (legal_q) begin
                            state_d   = StWrite;
                            we_d      = {sel_q[SelDdra], sel_q[SelPorta],
                                         sel_q[SelDdrb], sel_q[SelPortb]};
                            wr_data_d = bit_modify(read_val, bit_q, op_q == OpSbi);
                        end
                    end
                endcase
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        err_d  = (state_d == StDone) & ~legal_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            op_q      <= OpIn;
            bit_q     <= 3'd0;
            sel_q     <= '0;
            legal_q   <= 1'b0;
            wr_data_q <= 8'h00;
            we_q      <= 4'b0000;
            rdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            bit_q     <= bit_d;
            sel_q     <= sel_d;
            legal_q   <= legal_d;
            wr_data_q <= wr_data_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_data  = wr_data_q;
    assign ddra_we  = we_q[3];
    assign porta_we = we_q[2];
    assign ddrb_we  = we_q[1];
    assign portb_we = we_q[0];
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
